// File: rtl/score_report_pkg.sv
// score_report_pkg: definitions shared by the score reporter UART.
//   - ASCII constants used to build the 6-byte "S<hex>R<hex>\r\n" record
//   - RECORD_LEN / LAST_BYTE for the byte index
//   - serialiser state encoding (tx_state_t) and record state (rec_state_t)
//   - hex_to_ascii(): 4-bit value to uppercase ASCII hex digit
// Build option: SCORE_REPORT_PARITY_EN adds the even-parity state (8E1 framing).
package score_report_pkg;

    localparam int RECORD_LEN = 6;
    localparam logic [2:0] LAST_BYTE = 3'(RECORD_LEN - 1);

    localparam logic [7:0] CHAR_S         = 8'h53;
    localparam logic [7:0] CHAR_R         = 8'h52;
    localparam logic [7:0] CHAR_CR        = 8'h0D;
    localparam logic [7:0] CHAR_LF        = 8'h0A;
    localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;  // '0'
    localparam logic [7:0] HEX_ALPHA_BASE = 8'h41;  // 'A'

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef SCORE_REPORT_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } tx_state_t;

    typedef enum logic {
        REC_IDLE = 1'b0,
        REC_SEND = 1'b1
    } rec_state_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] value);
        logic [7:0] v8;
        v8 = {4'd0, value};
        if (value < 4'd10)
            return HEX_DIGIT_BASE + v8;
        else
            return HEX_ALPHA_BASE + v8 - 8'd10;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte as start bit, 8 data bits LSB first,
// optional even parity bit, stop bit. Each bit lasts CLKS_PER_BIT cycles.
// Ports:
//   clk, reset (async, active-low)
//   start      load data and begin a frame (sampled in IDLE and in the last
//              stop-bit cycle, so frames can be chained with no gap)
//   data[7:0]  byte to send, captured when start is taken
//   done       high during the final cycle of the stop bit
//   tx         registered serial output, idle high
// Build option: SCORE_REPORT_PARITY_EN inserts the PARITY state (8E1).
//
// state  | meaning
// IDLE   | line idle (tx=1), waiting for start
// START  | start bit (tx=0)
// DATA   | data bits, bit_cnt selects the bit
// PARITY | even parity over the data byte (parity builds only)
// STOP   | stop bit (tx=1); done on its last cycle
module uart_byte_tx
    import score_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    data_q, data_n;
    logic          tx_n;
    logic          bit_end;

    assign bit_end = (timer == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            data_q  <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            data_q  <= data_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer + TW'(1);
        bit_cnt_n = bit_cnt;
        data_n    = data_q;
        unique case (state)
            ST_IDLE: begin
                timer_n = '0;
                if (start) begin
                    state_n   = ST_START;
                    bit_cnt_n = '0;
                    data_n    = data;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    timer_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_n = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
`ifdef SCORE_REPORT_PARITY_EN
                        state_n   = ST_PARITY;
`else
                        state_n   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef SCORE_REPORT_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    timer_n = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    timer_n = '0;
                    // Chaining straight into the next start bit keeps the
                    // record gap-free between bytes.
                    if (start) begin
                        state_n   = ST_START;
                        bit_cnt_n = '0;
                        data_n    = data;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                timer_n = '0;
            end
        endcase
    end

    // tx is registered from the next-state values so the line level changes
    // on the same edge as the state.
    always_comb begin
        done = (state == ST_STOP) && bit_end;
        tx_n = 1'b1;
        unique case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = data_n[bit_cnt_n];
`ifdef SCORE_REPORT_PARITY_EN
            ST_PARITY: tx_n = ^data_n;
`endif
            default:   tx_n = 1'b1;
        endcase
    end

endmodule

// File: rtl/score_uart_tx.sv
// score_uart_tx: sends a score/target pair as the ASCII record
// "S<hex score>R<hex target>\r\n" over a UART line (8N1, or 8E1 when
// SCORE_REPORT_PARITY_EN is defined).
// Parameters: CLK_HZ, BAUD; CLKS_PER_BIT = CLK_HZ/BAUD is derived.
// Ports:
//   clk, reset (async, active-low)
//   report_valid / report_ready  handshake; score/target latched on transfer
//   score[3:0], target[3:0]      values to report
//   tx                           serial output, idle high
//   busy                         high from acceptance to end of last stop bit
//
// state    | meaning
// REC_IDLE | ready for a report (report_ready=1 once out of reset)
// REC_SEND | record in flight; byte_idx is the byte on the line
module score_uart_tx
    import score_report_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       report_valid,
    output logic       report_ready,
    input  logic [3:0] score,
    input  logic [3:0] target,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    rec_state_t rec_state, rec_state_n;
    logic [2:0] byte_idx, byte_idx_n;
    logic [2:0] next_sel;
    logic [3:0] score_q, target_q;
    logic       accept;
    logic       byte_start;
    logic       byte_done;
    logic [7:0] byte_data;

    assign accept = report_valid && report_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec_state    <= REC_IDLE;
            byte_idx     <= '0;
            score_q      <= '0;
            target_q     <= '0;
            report_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rec_state    <= rec_state_n;
            byte_idx     <= byte_idx_n;
            report_ready <= (rec_state_n == REC_IDLE);
            busy         <= (rec_state_n == REC_SEND);
            if (accept) begin
                score_q  <= score;
                target_q <= target;
            end
        end
    end

    always_comb begin
        rec_state_n = rec_state;
        byte_idx_n  = byte_idx;
        unique case (rec_state)
            REC_IDLE: begin
                if (accept) begin
                    rec_state_n = REC_SEND;
                    byte_idx_n  = '0;
                end
            end
            REC_SEND: begin
                if (byte_done) begin
                    if (byte_idx == LAST_BYTE)
                        rec_state_n = REC_IDLE;
                    else
                        byte_idx_n = byte_idx + 3'd1;
                end
            end
            default: rec_state_n = REC_IDLE;
        endcase
    end

    // The serialiser captures data when start is taken, which is either the
    // accept edge (byte 0) or the last stop-bit cycle of the previous byte,
    // so the mux presents the byte that is about to begin.
    always_comb begin
        byte_start = accept ||
                     ((rec_state == REC_SEND) && byte_done && (byte_idx != LAST_BYTE));
        next_sel   = (rec_state == REC_IDLE) ? 3'd0 : byte_idx + 3'd1;
        unique case (next_sel)
            3'd0:    byte_data = CHAR_S;
            3'd1:    byte_data = hex_to_ascii(score_q);
            3'd2:    byte_data = CHAR_R;
            3'd3:    byte_data = hex_to_ascii(target_q);
            3'd4:    byte_data = CHAR_CR;
            3'd5:    byte_data = CHAR_LF;
            default: byte_data = 8'hFF;
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk   (clk),
        .reset (reset),
        .start (byte_start),
        .data  (byte_data),
        .done  (byte_done),
        .tx    (tx)
    );

endmodule

// File: tb/tb_score_uart_tx.sv
// Testbench for score_uart_tx. Two instances share the clock: dut_d at the
// default 50 MHz / 115200 (434 cycles per bit) and dut_f with 16 cycles per
// bit for the long back-to-back sequence.
module tb_score_uart_tx;

    localparam int CPB_D  = 50_000_000 / 115200;
    localparam int CLK_F  = 1_600_000;
    localparam int BAUD_F = 100_000;
    localparam int CPB_F  = CLK_F / BAUD_F;
`ifdef SCORE_REPORT_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MAXC = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, valid_d, ready_d, tx_d, busy_d;
    logic [3:0] score_d, target_d;
    logic       rst_f, valid_f, ready_f, tx_f, busy_f;
    logic [3:0] score_f, target_f;

    score_uart_tx dut_d (
        .clk          (clk),
        .reset        (rst_d),
        .report_valid (valid_d),
        .report_ready (ready_d),
        .score        (score_d),
        .target       (target_d),
        .tx           (tx_d),
        .busy         (busy_d)
    );

    score_uart_tx #(.CLK_HZ(CLK_F), .BAUD(BAUD_F)) dut_f (
        .clk          (clk),
        .reset        (rst_f),
        .report_valid (valid_f),
        .report_ready (ready_f),
        .score        (score_f),
        .target       (target_f),
        .tx           (tx_f),
        .busy         (busy_f)
    );

    int   n_vec = 0;
    int   n_err = 0;
    logic sel = 1'b0;
    logic mon_tx, mon_busy, mon_ready;
    assign mon_tx    = sel ? tx_f    : tx_d;
    assign mon_busy  = sel ? busy_f  : busy_d;
    assign mon_ready = sel ? ready_f : ready_d;

    logic cap_tx    [MAXC];
    logic cap_busy  [MAXC];
    logic cap_ready [MAXC];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_model(input int v);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + v - 10);
    endfunction

    task automatic drive(input logic v, input logic [3:0] sc, input logic [3:0] tg);
        if (sel) begin
            valid_f = v; score_f = sc; target_f = tg;
        end else begin
            valid_d = v; score_d = sc; target_d = tg;
        end
    endtask

    // Returns at the negedge of the first cycle after the accept edge.
    task automatic start_report(input logic [3:0] sc, input logic [3:0] tg);
        int t;
        @(negedge clk);
        drive(1'b1, sc, tg);
        t = 0;
        while (mon_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("ready_wait", mon_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            cap_tx[c]    = mon_tx;
            cap_busy[c]  = mon_busy;
            cap_ready[c] = mon_ready;
        end
    endtask

    task automatic analyze(input string tag, input int off, input int sc, input int tg);
        int         cpb, len, werr, bcnt, p, j, b;
        logic [7:0] eb [6];
        logic [7:0] gb;
        logic       ebit;
        cpb = sel ? CPB_F : CPB_D;
        len = 6 * FB * cpb;
        eb[0] = 8'h53; eb[1] = hex_model(sc); eb[2] = 8'h52;
        eb[3] = hex_model(tg); eb[4] = 8'h0D; eb[5] = 8'h0A;
        for (int jj = 0; jj < 6; jj++) begin
            for (int k = 0; k < 8; k++)
                gb[k] = cap_tx[off + (jj * FB + 1 + k) * cpb + cpb / 2];
            check_val($sformatf("%s_byte%0d", tag, jj), {24'd0, gb}, {24'd0, eb[jj]});
        end
        werr = 0;
        bcnt = 0;
        for (int c = 0; c < len; c++) begin
            p = c / cpb;
            j = p / FB;
            b = p % FB;
            if (b == 0)                    ebit = 1'b0;
            else if (b <= 8)               ebit = eb[j][b - 1];
            else if (FB == 11 && b == 9)   ebit = ^eb[j];
            else                           ebit = 1'b1;
            if (cap_tx[off + c] !== ebit) werr++;
            if (cap_busy[off + c] === 1'b1) bcnt++;
        end
        check_val({tag, "_wave_errs"}, werr, 0);
        check_val({tag, "_busy_len"}, bcnt, len);
        check_val({tag, "_ready_during"}, cap_ready[off], 1'b0);
        check_val({tag, "_busy_after"}, cap_busy[off + len], 1'b0);
        check_val({tag, "_ready_after"}, cap_ready[off + len], 1'b1);
        check_val({tag, "_tx_after"}, cap_tx[off + len], 1'b1);
    endtask

    initial begin
        int ld, lf;
        ld = 6 * FB * CPB_D;
        lf = 6 * FB * CPB_F;

        // Reset with random inputs applied
        rst_d = 1'b0; rst_f = 1'b0;
        valid_d = 1'b0; score_d = '0; target_d = '0;
        valid_f = 1'b0; score_f = '0; target_f = '0;
        repeat (5) begin
            @(negedge clk);
            valid_d = 1'($urandom); score_d = 4'($urandom); target_d = 4'($urandom);
            valid_f = 1'($urandom); score_f = 4'($urandom); target_f = 4'($urandom);
        end
        check_val("rst_tx_d", tx_d, 1'b1);
        check_val("rst_busy_d", busy_d, 1'b0);
        check_val("rst_ready_d", ready_d, 1'b0);
        check_val("rst_tx_f", tx_f, 1'b1);
        check_val("rst_busy_f", busy_f, 1'b0);
        check_val("rst_ready_f", ready_f, 1'b0);
        valid_d = 1'b0; valid_f = 1'b0;
        @(negedge clk);
        rst_d = 1'b1; rst_f = 1'b1;
        #1;
        check_val("ready_at_release", ready_d, 1'b0);
        @(negedge clk);
        check_val("ready_1clk_d", ready_d, 1'b1);
        check_val("ready_1clk_f", ready_f, 1'b1);

        // Basic record; score changes one cycle after accept
        sel = 1'b0;
        start_report(4'd3, 4'd12);
        valid_d = 1'b0;
        score_d = 4'd9;
        capture(ld + 1);
        analyze("basic", 0, 3, 12);

        // Reset during byte 2, on a data bit that drives 0
        start_report(4'd5, 4'd5);
        valid_d = 1'b0;
        repeat (2 * FB * CPB_D + CPB_D + CPB_D / 2) @(negedge clk);
        check_val("pre_rst_tx", tx_d, 1'b0);
        check_val("pre_rst_busy", busy_d, 1'b1);
        rst_d = 1'b0;
        #1;
        check_val("mid_rst_tx", tx_d, 1'b1);
        check_val("mid_rst_busy", busy_d, 1'b0);
        check_val("mid_rst_ready", ready_d, 1'b0);
        repeat (3) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", ready_d, 1'b1);
        check_val("post_rst_tx", tx_d, 1'b1);
        start_report(4'd1, 4'd1);
        valid_d = 1'b0;
        capture(ld + 1);
        analyze("after_rst", 0, 1, 1);

        // Back-to-back with valid held high
        sel = 1'b1;
        start_report(4'd15, 4'd0);
        capture(2 * lf + 2);
        valid_f = 1'b0;
        analyze("b2b_first", 0, 15, 0);
        check_val("b2b_gap_busy", cap_busy[lf], 1'b0);
        analyze("b2b_second", lf + 1, 15, 0);

`ifdef SCORE_REPORT_PARITY_EN
        // 0x37 carries five ones, so even parity is 1
        start_report(4'd7, 4'd3);
        valid_f = 1'b0;
        capture(lf + 1);
        analyze("parity", 0, 7, 3);
        check_val("parity_bit", cap_tx[(1 * FB + 9) * CPB_F + CPB_F / 2], 1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
